slow_clk_bank: RTL

Multi-channel programmable clock-enable generator, successor to the fixed single-output slow clock divider. It derives `CHANNELS` independent divided outputs from `fast_clk`. Each output is a 50 % toggle clock plus a one-cycle tick strobe. Each channel has its own run-time divisor, loaded through a valid/ready port and applied glitch-free at the channel's next half-period boundary. It sits at the top level, feeding display multiplexing, debouncers and blink logic with both slow clocks and fast-domain enables.

---
 rtl/slow_clk_pkg.sv | 12 +
 rtl/slow_clk_chan.sv | 82 ++++++++
 rtl/slow_clk_bank.sv | 52 +++++
 3 files changed

// File: rtl/slow_clk_pkg.sv
// Shared constants and helpers for the slow_clk_bank divider family.
package slow_clk_pkg;

  localparam int unsigned CNT_W_DEF = 16;
  localparam logic [15:0] DEFAULT_DIV_DEF = 16'hFFFF;

  // Channel-select width; a single channel still gets a 1-bit select.
  function automatic int unsigned chan_w(input int unsigned n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/slow_clk_chan.sv
// One divider channel: half-period counter, shadow divisor and registered outputs.
module slow_clk_chan
  import slow_clk_pkg::*;
#(
  parameter int unsigned      CNT_W       = CNT_W_DEF,
  parameter logic [CNT_W-1:0] DEFAULT_DIV = CNT_W'(DEFAULT_DIV_DEF)
) (
  input  logic             fast_clk_i,
  input  logic             rst_i,
  input  logic             en_i,
  input  logic             load_i,
  input  logic [CNT_W-1:0] load_div_i,
  output logic             slow_clk_o,
  output logic             tick_o,
  output logic             pend_o
);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] div_act_q, div_act_d;
  logic [CNT_W-1:0] div_sh_q, div_sh_d;
  logic             pend_q, pend_d;
  logic             slow_q, slow_d;
  logic             tick_q, tick_d;
  logic [CNT_W-1:0] last_cnt;

  // Divisor 0 behaves as 1, so the terminal count is 0 in both cases.
  assign last_cnt = (div_act_q == '0) ? '0 : div_act_q - CNT_W'(1);

  always_comb begin
    cnt_d     = cnt_q;
    div_act_d = div_act_q;
    div_sh_d  = div_sh_q;
    pend_d    = pend_q;
    slow_d    = slow_q;
    tick_d    = 1'b0;
    if (en_i) begin
      if (cnt_q == last_cnt) begin
        cnt_d  = '0;
        slow_d = ~slow_q;
        tick_d = 1'b1;
        if (pend_q) begin
          div_act_d = div_sh_q;
          pend_d    = 1'b0;
        end
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end else if (pend_q) begin
      div_act_d = div_sh_q;
      pend_d    = 1'b0;
      cnt_d     = '0;
    end
    // load_i is only raised while pend_q is clear, so it never races the apply above.
    if (load_i) begin
      div_sh_d = load_div_i;
      pend_d   = 1'b1;
    end
  end

  always_ff @(posedge fast_clk_i) begin
    if (rst_i) begin
      cnt_q     <= '0;
      div_act_q <= DEFAULT_DIV;
      div_sh_q  <= DEFAULT_DIV;
      pend_q    <= 1'b0;
      slow_q    <= 1'b0;
      tick_q    <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      div_act_q <= div_act_d;
      div_sh_q  <= div_sh_d;
      pend_q    <= pend_d;
      slow_q    <= slow_d;
      tick_q    <= tick_d;
    end
  end

  assign slow_clk_o = slow_q;
  assign tick_o     = tick_q;
  assign pend_o     = pend_q;

endmodule

// File: rtl/slow_clk_bank.sv
// Bank of independent programmable clock dividers with a shared divisor-load port.
module slow_clk_bank
  import slow_clk_pkg::*;
#(
  parameter int unsigned      CHANNELS    = 4,
  parameter int unsigned      CNT_W       = CNT_W_DEF,
  parameter logic [CNT_W-1:0] DEFAULT_DIV = CNT_W'(DEFAULT_DIV_DEF),
  localparam int unsigned     CHAN_W      = chan_w(CHANNELS)
) (
  input  logic                fast_clk_i,
  input  logic                rst_i,
  input  logic [CHANNELS-1:0] en_i,
  input  logic                cfg_valid_i,
  output logic                cfg_ready_o,
  input  logic [CHAN_W-1:0]   cfg_chan_i,
  input  logic [CNT_W-1:0]    cfg_div_i,
  output logic [CHANNELS-1:0] slow_clk_o,
  output logic [CHANNELS-1:0] tick_o
);

  logic [CHANNELS-1:0] pend;
  logic [CHANNELS-1:0] load;

  // Out-of-range selects match no channel: always ready, load silently dropped.
  always_comb begin
    cfg_ready_o = 1'b1;
    load        = '0;
    for (int unsigned i = 0; i < CHANNELS; i++) begin
      if (cfg_chan_i == CHAN_W'(i)) begin
        cfg_ready_o = ~pend[i];
        load[i]     = cfg_valid_i & ~pend[i];
      end
    end
  end

  for (genvar g = 0; g < CHANNELS; g++) begin : g_chan
    slow_clk_chan #(
      .CNT_W       (CNT_W),
      .DEFAULT_DIV (DEFAULT_DIV)
    ) u_chan (
      .fast_clk_i (fast_clk_i),
      .rst_i      (rst_i),
      .en_i       (en_i[g]),
      .load_i     (load[g]),
      .load_div_i (cfg_div_i),
      .slow_clk_o (slow_clk_o[g]),
      .tick_o     (tick_o[g]),
      .pend_o     (pend[g])
    );
  end

endmodule
